// File: rtl/reg_write_arbiter_if.sv
// Request lanes and registered write port between the requesters and reg_write_arbiter.
interface reg_write_arbiter_if #(
  parameter int NREQ = 4,
  parameter int PW   = 4
);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]    ReqValid;
  logic [NREQ-1:0]    ReqReady;
  logic [NREQ*PW-1:0] ReqAddr;
  logic [NREQ*2-1:0]  ReqKind;
  logic [NREQ*8-1:0]  ReqData;

  logic               WriteEn;
  logic [PW-1:0]      Waddr;
  logic [7:0]         DataIn;
  logic [5:0]         ImmediateVal;
  logic [PW-1:0]      MoveFrom;
  logic               Imm;
  logic               Move;
  logic [IW-1:0]      GrantId;
  logic               Busy;
  logic               KindErr;

  modport master (
    output ReqValid, ReqAddr, ReqKind, ReqData,
    input  ReqReady, WriteEn, Waddr, DataIn, ImmediateVal, MoveFrom,
    input  Imm, Move, GrantId, Busy, KindErr
  );

  modport slave (
    input  ReqValid, ReqAddr, ReqKind, ReqData,
    output ReqReady, WriteEn, Waddr, DataIn, ImmediateVal, MoveFrom,
    output Imm, Move, GrantId, Busy, KindErr
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// Arbitrates NREQ requesters onto the single register-file write port through one pending slot.
// Define REG_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module reg_write_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = 4
) (
  input logic               Clk,
  input logic               Reset,
  input logic               Freeze,
  reg_write_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    HELD = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [NREQ-1:0] grant_s;
  logic [IW-1:0]   win_s;
  logic [IW-1:0]   pick_s;
  logic            take_s;
  logic            found_s;
  logic            accept_ok_s;
  logic            xfer_s;
  logic [PW-1:0]   sel_addr_s;
  logic [1:0]      sel_kind_s;
  logic [7:0]      sel_data_s;
  logic [PW-1:0]   waddr_r;
  logic [1:0]      kind_r;
  logic [7:0]      data_r;
  logic [5:0]      imm_r;
  logic [PW-1:0]   move_from_r;
  logic [IW-1:0]   gid_r;
  logic            kind_err_r;
  logic            busy_s;
  logic            write_en_s;

`ifdef REG_ARB_RR_EN
  logic [IW-1:0]   ptr_r;
`endif

  // One-hot winner search, starting at the RR pointer or at index 0
  always_comb begin
    grant_s = '0;
    win_s   = '0;
    found_s = 1'b0;
    pick_s  = '0;
    take_s  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef REG_ARB_RR_EN
      pick_s = IW'((int'(ptr_r) + k) % NREQ);
`else
      pick_s = IW'(k);
`endif
      take_s          = !found_s && bus.ReqValid[pick_s];
      grant_s[pick_s] = grant_s[pick_s] | take_s;
      win_s           = take_s ? pick_s : win_s;
      found_s         = found_s | take_s;
    end
  end

  assign accept_ok_s  = !Freeze && !Reset;
  assign xfer_s       = found_s && accept_ok_s;
  assign bus.ReqReady = accept_ok_s ? grant_s : {NREQ{1'b0}};

  // Winner payload mux; grant is one-hot so an OR of masked lanes suffices
  always_comb begin
    sel_addr_s = '0;
    sel_kind_s = 2'b00;
    sel_data_s = 8'h00;
    for (int k = 0; k < NREQ; k++) begin
      sel_addr_s = sel_addr_s | (bus.ReqAddr[k*PW +: PW] & {PW{grant_s[k]}});
      sel_kind_s = sel_kind_s | (bus.ReqKind[k*2 +: 2]   & {2{grant_s[k]}});
      sel_data_s = sel_data_s | (bus.ReqData[k*8 +: 8]   & {8{grant_s[k]}});
    end
  end

  // Pending-slot state register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: a frozen pending write parks in HELD, otherwise the slot reloads
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (xfer_s) begin
          state_nxt_s = PEND;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      PEND, HELD: begin
        if (Freeze) begin
          state_nxt_s = HELD;
        end else if (xfer_s) begin
          state_nxt_s = PEND;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Payload fields; only the field matching the kind is replaced, the rest keep old values
  always_ff @(posedge Clk) begin
    if (Reset) begin
      waddr_r     <= '0;
      kind_r      <= 2'b00;
      data_r      <= 8'h00;
      imm_r       <= 6'h00;
      move_from_r <= '0;
      gid_r       <= '0;
    end else if (xfer_s) begin
      waddr_r <= sel_addr_s;
      kind_r  <= sel_kind_s;
      gid_r   <= win_s;
      case (sel_kind_s)
        2'b00:   data_r      <= sel_data_s;
        2'b01:   imm_r       <= sel_data_s[5:0];
        2'b10:   move_from_r <= sel_data_s[PW-1:0];
        default: data_r      <= data_r;
      endcase
    end else begin
      waddr_r <= waddr_r;
    end
  end

  // Sticky flag for an accepted illegal kind
  always_ff @(posedge Clk) begin
    if (Reset) begin
      kind_err_r <= 1'b0;
    end else if (xfer_s && (sel_kind_s == 2'b11)) begin
      kind_err_r <= 1'b1;
    end else begin
      kind_err_r <= kind_err_r;
    end
  end

`ifdef REG_ARB_RR_EN
  // Search pointer moves past the winner only when a transfer happens
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ptr_r <= '0;
    end else if (xfer_s) begin
      ptr_r <= (win_s == IW'(NREQ - 1)) ? '0 : win_s + IW'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end
`endif

  assign busy_s     = (state_r != IDLE);
  assign write_en_s = busy_s && !Freeze && !Reset && (kind_r != 2'b11);

  assign bus.WriteEn      = write_en_s;
  assign bus.Waddr        = waddr_r;
  assign bus.DataIn       = data_r;
  assign bus.ImmediateVal = imm_r;
  assign bus.MoveFrom     = move_from_r;
  assign bus.Imm          = write_en_s && (kind_r == 2'b01);
  assign bus.Move         = write_en_s && (kind_r == 2'b10);
  assign bus.GrantId      = gid_r;
  assign bus.Busy         = busy_s;
  assign bus.KindErr      = kind_err_r;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: stimulus pushes expected writes, a negedge monitor checks them.
module tb_reg_write_arbiter;
  localparam int NREQ = 4;
  localparam int PW   = 4;

  typedef struct {
    int         cyc;
    logic [3:0] addr;
    logic [1:0] kind;
    logic [7:0] data;
    logic [1:0] gid;
  } wr_t;

  logic Clk = 1'b0;
  logic Reset;
  logic Freeze;
  int   cyc = 0;

  wr_t  exp_q[$];
  logic st_chk = 1'b0;
  logic [3:0] st_ready = 4'h0;
  logic st_busy = 1'b0;
  logic st_kerr = 1'b0;
  logic st_we = 1'b0;
  logic st_chk_addr = 1'b0;
  logic [3:0] st_addr = 4'h0;
  logic tb_done = 1'b0;

  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   rd_idx = 0;
  logic mon_done = 1'b0;

  reg_write_arbiter_if #(.NREQ(NREQ), .PW(PW)) bus ();

  reg_write_arbiter #(.NREQ(NREQ), .PW(PW)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Freeze(Freeze),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic req(input logic [3:0] v, input logic [15:0] a, input logic [7:0] k,
                     input logic [31:0] d);
    bus.ReqValid = v;
    bus.ReqAddr  = a;
    bus.ReqKind  = k;
    bus.ReqData  = d;
  endtask

  task automatic status(input logic [3:0] rdy, input logic busy, input logic kerr,
                        input logic we, input logic chka, input logic [3:0] addr);
    st_chk      = 1'b1;
    st_ready    = rdy;
    st_busy     = busy;
    st_kerr     = kerr;
    st_we       = we;
    st_chk_addr = chka;
    st_addr     = addr;
  endtask

  task automatic push(input int dly, input logic [3:0] addr, input logic [1:0] kind,
                      input logic [7:0] data, input logic [1:0] gid);
    wr_t e;
    e.cyc  = cyc + dly;
    e.addr = addr;
    e.kind = kind;
    e.data = data;
    e.gid  = gid;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset  = 1'b1;
    Freeze = 1'b0;
    st_chk = 1'b0;
    st_chk_addr = 1'b0;
    req(4'($urandom()), 16'($urandom()), 8'($urandom()), $urandom());
    step();
    req(4'($urandom()), 16'($urandom()), 8'($urandom()), $urandom());
    status(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    step();
    Reset = 1'b0;
    req(4'h0, 16'h0000, 8'h00, 32'h0);
  endtask

  // Monitor: status checks each cycle plus in-order scoreboard of issued writes
  initial begin
    wr_t e;
    logic [7:0] act_pl;
    logic [7:0] exp_pl;
    forever begin
      @(negedge Clk);
      if (st_chk) begin
        vec_cnt++;
        if ({bus.ReqReady, bus.Busy, bus.KindErr, bus.WriteEn} !== {st_ready, st_busy, st_kerr, st_we}) begin
          err_cnt++;
          $display("FAIL status cyc=%0d got ready=%b busy=%b kerr=%b we=%b, want ready=%b busy=%b kerr=%b we=%b",
                   cyc, bus.ReqReady, bus.Busy, bus.KindErr, bus.WriteEn, st_ready, st_busy, st_kerr, st_we);
        end
      end
      if (st_chk && st_chk_addr) begin
        vec_cnt++;
        if (bus.Waddr !== st_addr) begin
          err_cnt++;
          $display("FAIL waddr_hold cyc=%0d got %0d want %0d", cyc, bus.Waddr, st_addr);
        end
      end
      if (bus.WriteEn === 1'b1) begin
        vec_cnt++;
        if (rd_idx >= exp_q.size()) begin
          err_cnt++;
          $display("FAIL unexpected_write cyc=%0d waddr=%0d gid=%0d, want no write", cyc, bus.Waddr, bus.GrantId);
        end else begin
          e = exp_q[rd_idx];
          rd_idx++;
          case (e.kind)
            2'd1: begin act_pl = {2'b00, bus.ImmediateVal}; exp_pl = {2'b00, e.data[5:0]}; end
            2'd2: begin act_pl = {4'h0, bus.MoveFrom};      exp_pl = {4'h0, e.data[3:0]}; end
            default: begin act_pl = bus.DataIn;             exp_pl = e.data; end
          endcase
          if (cyc != e.cyc ||
              {bus.Waddr, bus.GrantId, bus.Imm, bus.Move, act_pl} !==
              {e.addr, e.gid, (e.kind == 2'd1), (e.kind == 2'd2), exp_pl}) begin
            err_cnt++;
            $display("FAIL write got cyc=%0d waddr=%0d gid=%0d imm=%b move=%b payload=%h, want cyc=%0d waddr=%0d gid=%0d kind=%0d payload=%h",
                     cyc, bus.Waddr, bus.GrantId, bus.Imm, bus.Move, act_pl, e.cyc, e.addr, e.gid, e.kind, exp_pl);
          end
        end
      end else if (rd_idx < exp_q.size() && exp_q[rd_idx].cyc < cyc) begin
        vec_cnt++;
        err_cnt++;
        $display("FAIL missing_write got none by cyc=%0d, want waddr=%0d at cyc=%0d", cyc, exp_q[rd_idx].addr, exp_q[rd_idx].cyc);
        rd_idx++;
      end
      if (tb_done && !mon_done) begin
        mon_done = 1'b1;
        vec_cnt++;
        if (rd_idx != exp_q.size()) begin
          err_cnt++;
          $display("FAIL drain got %0d writes checked, want %0d", rd_idx, exp_q.size());
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    int w;
    bus.ReqValid = 4'h0;
    bus.ReqAddr  = 16'h0;
    bus.ReqKind  = 8'h0;
    bus.ReqData  = 32'h0;
    do_reset();

    // single data write from requester 0
    req(4'b0001, 16'h0003, 8'h00, 32'h0000_00A5);
    status(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    push(1, 4'd3, 2'd0, 8'hA5, 2'd0);
    step();
    req(4'h0, 16'h0, 8'h00, 32'h0);
    status(4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 4'd3);
    step();
    status(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    step();

    // all requesters valid for five cycles
    do_reset();
    req(4'b1111, {4'd11, 4'd10, 4'd9, 4'd8}, 8'h00, {8'h13, 8'h12, 8'h11, 8'h10});
    w = 0;
    for (int c = 0; c < 5; c++) begin
`ifdef REG_ARB_RR_EN
      w = c % 4;
`else
      w = 0;
`endif
      status(4'(1 << w), (c > 0), 1'b0, (c > 0), 1'b0, 4'h0);
      push(1, 4'(8 + w), 2'd0, 8'(8'h10 + w), 2'(w));
      step();
    end
    req(4'h0, 16'h0, 8'h00, 32'h0);
    status(4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 4'(8 + w));
    step();
    status(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    step();

    // freeze holds the pending write for three cycles, then back-to-back issue
    req(4'b0010, 16'h0060, 8'h00, 32'h0000_3C00);
    status(4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    push(4, 4'd6, 2'd0, 8'h3C, 2'd1);
    step();
    Freeze = 1'b1;
    req(4'b0100, 16'h0100, 8'h00, 32'h0011_0000);
    for (int c = 0; c < 3; c++) begin
      status(4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'd6);
      step();
    end
    Freeze = 1'b0;
    status(4'b0100, 1'b1, 1'b0, 1'b1, 1'b1, 4'd6);
    push(1, 4'd1, 2'd0, 8'h11, 2'd2);
    step();
    req(4'h0, 16'h0, 8'h00, 32'h0);
    status(4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 4'd1);
    step();
    status(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    step();

    // immediate then move
    req(4'b0010, 16'h0050, 8'h04, 32'h0000_2A00);
    status(4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    push(1, 4'd5, 2'd1, 8'h2A, 2'd1);
    step();
    req(4'b0100, 16'h0200, 8'h20, 32'h0007_0000);
    status(4'b0100, 1'b1, 1'b0, 1'b1, 1'b1, 4'd5);
    push(1, 4'd2, 2'd2, 8'h07, 2'd2);
    step();
    req(4'h0, 16'h0, 8'h00, 32'h0);
    status(4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 4'd2);
    step();
    status(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    step();

    // illegal kind: accepted, never written, KindErr sticks until reset
    req(4'b1000, 16'h9000, 8'hC0, 32'h0);
    status(4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    step();
    req(4'h0, 16'h0, 8'h00, 32'h0);
    status(4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 4'd9);
    step();
    status(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    step();
    req(4'b0001, 16'h000C, 8'h00, 32'h0000_005A);
    status(4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    push(1, 4'd12, 2'd0, 8'h5A, 2'd0);
    step();
    req(4'h0, 16'h0, 8'h00, 32'h0);
    status(4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 4'd12);
    step();
    status(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    step();

    // reset clears KindErr; then two requesters target the same register
    do_reset();
    req(4'b0011, 16'h0044, 8'h00, 32'h0000_4140);
    status(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    push(1, 4'd4, 2'd0, 8'h40, 2'd0);
    step();
    req(4'b0010, 16'h0044, 8'h00, 32'h0000_4140);
    status(4'b0010, 1'b1, 1'b0, 1'b1, 1'b1, 4'd4);
    push(1, 4'd4, 2'd0, 8'h41, 2'd1);
    step();
    req(4'h0, 16'h0, 8'h00, 32'h0);
    status(4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 4'd4);
    step();
    status(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    step();

    st_chk  = 1'b0;
    tb_done = 1'b1;
    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
